// File: rtl/mod_n_updown_counter_if.sv
// Control/data bundle for mod_n_updown_counter: raw button, step controls, load path and count outputs.
// master drives the controls, slave is the counter.
interface mod_n_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             x;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             z;

  modport master (
    output x, en, up, load, load_val,
    input  q, z
  );

  modport slave (
    input  x, en, up, load, load_val,
    output q, z
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter stepped by the release edge of a synchronised button level.
// Optional MOD_N_DEBOUNCE_EN inserts a stable-cycle filter between the synchroniser and the edge detector.
module mod_n_updown_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned MODULUS         = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   cp,
  input  logic                   rst,
  mod_n_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // Reject illegal configurations at elaboration time.
  if ((MODULUS < 2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mod_n_updown_counter: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("mod_n_updown_counter: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   xs;
  logic                   xf;
  logic                   xp_q;
  logic                   step;
  logic [WIDTH-1:0]       q_q, q_d;
  logic                   z_q, z_d;
  logic                   load_ok;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.x};
  assign xs     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge cp) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef MOD_N_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            xf_q, xf_d;

  // xf follows xs only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d = '0;
    xf_d     = xf_q;
    if (xs != xf_q) begin
      if (db_cnt_q == DB_LAST) begin
        xf_d = xs;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      db_cnt_q <= '0;
      xf_q     <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      xf_q     <= xf_d;
    end
  end

  assign xf = xf_q;
`else
  assign xf = xs;
`endif

  // Release of the button (1 -> 0) is the count event.
  always_ff @(posedge cp) begin
    if (rst) begin
      xp_q <= 1'b0;
    end else begin
      xp_q <= xf;
    end
  end

  assign step    = xp_q & ~xf;
  assign load_ok = {1'b0, bus.load_val} < MOD_EXT;

  // Priority: load over step; the limit is compared before stepping so q stays below MODULUS.
  always_comb begin
    q_d = q_q;
    z_d = 1'b0;
    if (bus.load) begin
      q_d = load_ok ? bus.load_val : MAX_Q;
    end else if (step && bus.en) begin
      if (bus.up) begin
        if (q_q == MAX_Q) begin
          q_d = '0;
          z_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d = MAX_Q;
          z_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      q_q <= '0;
      z_q <= 1'b0;
    end else begin
      q_q <= q_d;
      z_q <= z_d;
    end
  end

  assign bus.q = q_q;
  assign bus.z = z_q;

endmodule
